// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM encoding and word width for the data memory responder.
package data_mem_responder_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: DEPTH x 32 byte-writable synchronous RAM, one write port and one registered read port.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (i_we && i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding valid/ready data memory with fixed response latency.
// Memory is accessed only on the edge entering RESP; errors never touch memory.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t r_state, w_next;
  logic r_live, r_we, r_err, r_load_ok;
  logic [3:0] r_cnt, r_be;
  logic [31:0] r_addr;
  logic [WORD_W-1:0] r_wdata, w_ram_rdata;
  logic w_idle, w_req_xfer, w_enter, w_we, w_err;
  logic [3:0] w_be;
  logic [31:0] w_addr;
  logic [WORD_W-1:0] w_wdata;
  assign w_idle     = r_state == IDLE;
  assign w_req_xfer = req_valid && req_ready;
  // with LATENCY 0 the access happens on the accept edge, so use the live request
  assign w_we    = w_idle ? req_we    : r_we;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_be    = w_idle ? req_be    : r_be;
  assign w_err   = (|w_addr[1:0]) || ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
  assign w_enter = (w_next == RESP) && (r_state != RESP);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = (w_idle && w_req_xfer) ? ((LATENCY == 0) ? RESP : WAIT)
           : (r_state == WAIT && r_cnt == 4'd0) ? RESP
           : (r_state == RESP && resp_ready) ? IDLE
           : r_state;
  end
  always_comb begin
    req_ready  = r_live && w_idle;
    resp_valid = r_state == RESP;
    resp_rdata = r_load_ok ? w_ram_rdata : '0;
    resp_err   = r_err;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live    <= 1'b0;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= 4'd0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_idle && w_req_xfer) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter) begin
        r_err     <= w_err;
        r_load_ok <= !w_we && !w_err;
      end else if (resp_valid && resp_ready) begin
        r_err     <= 1'b0;
        r_load_ok <= 1'b0;
      end
    end
  end
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .i_we    (w_enter && w_we && !w_err),
    .i_be    (w_be),
    .i_waddr (w_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .i_re    (w_enter && !w_we && !w_err),
    .i_raddr (w_addr[AW+1:2]),
    .o_rdata (w_ram_rdata)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of a LATENCY=2/DEPTH=64 instance (0) and a LATENCY=0/DEPTH=16 instance (1).
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid [2];
  logic req_ready [2];
  logic req_we [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [3:0] req_be [2];
  logic resp_valid [2];
  logic resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic resp_err [2];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH(64), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );
  data_mem_responder #(.DEPTH(16), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );
  task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int n;
    req_valid[d] = 1'b1;
    req_we[d] = we;
    req_addr[d] = addr;
    req_wdata[d] = wdata;
    req_be[d] = be;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) begin
      tests++; fails++;
      $display("FAIL accept_timeout dut%0d got req_ready=%b want 1", d, req_ready[d]);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask
  task automatic await_resp(input int d, output int lat, output logic [31:0] rdata, output logic err);
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (lat == 40) begin
      tests++; fails++;
      $display("FAIL resp_timeout dut%0d got resp_valid=%b want 1", d, resp_valid[d]);
    end
    rdata = resp_rdata[d];
    err = resp_err[d];
  endtask
  task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                      output int lat, output logic [31:0] rdata, output logic err);
    issue(d, we, addr, wdata, be);
    await_resp(d, lat, rdata, err);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]} !== 35'd0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d got rr=%b rv=%b err=%b rdata=%h want all 0", d, req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests++;
    if (req_ready[0] !== 1'b0) begin fails++; $display("FAIL ready_before_edge got %b want 0", req_ready[0]); end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (req_ready[d] !== 1'b1) begin fails++; $display("FAIL ready_after_edge dut%0d got %b want 1", d, req_ready[d]); end
    end
  endtask
  task automatic test_store_word;
    int lat; logic [31:0] rd; logic err;
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, err);
    tests++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("FAIL store_word got lat=%0d err=%b rdata=%h want 3 0 00000000", lat, err, rd);
    end
  endtask
  task automatic test_partial;
    int lat; logic [31:0] rd; logic err;
    xact(0, 1'b1, 32'h10, 32'h00000055, 4'b0001, lat, rd, err);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err);
    tests++;
    if (rd !== 32'hDEADBE55 || err !== 1'b0 || lat !== 3) begin
      fails++; $display("FAIL partial_b0 got rdata=%h err=%b lat=%0d want deadbe55 0 3", rd, err, lat);
    end
    xact(0, 1'b1, 32'h10, 32'hAABB0000, 4'b1100, lat, rd, err);
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, err);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL be0_err got %b want 0", err); end
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err);
    tests++;
    if (rd !== 32'hAABBBE55) begin fails++; $display("FAIL partial_hi got rdata=%h want aabbbe55", rd); end
  endtask
  task automatic test_errors;
    int lat; logic [31:0] rd; logic err;
    xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, rd, err);
    xact(0, 1'b0, 32'h13, 32'h0, 4'h0, lat, rd, err);
    tests++;
    if (err !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misaligned_load got err=%b rdata=%h want 1 00000000", err, rd); end
    xact(0, 1'b1, 32'h100, 32'h11111111, 4'hF, lat, rd, err);
    tests++;
    if (err !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL range_store got err=%b rdata=%h want 1 00000000", err, rd); end
    xact(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, lat, rd, err);
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL misaligned_store got err=%b want 1", err); end
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, err);
    tests++;
    if (rd !== 32'hCAFEF00D || err !== 1'b0) begin fails++; $display("FAIL word0_intact got rdata=%h err=%b want cafef00d 0", rd, err); end
    xact(0, 1'b1, 32'hFC, 32'h0BADCAFE, 4'hF, lat, rd, err);
    xact(0, 1'b0, 32'hFC, 32'h0, 4'h0, lat, rd, err);
    tests++;
    if (rd !== 32'h0BADCAFE || err !== 1'b0) begin fails++; $display("FAIL last_word got rdata=%h err=%b want 0badcafe 0", rd, err); end
  endtask
  task automatic test_backpressure;
    int lat; logic [31:0] rd; logic err; int bad;
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    await_resp(0, lat, rd, err);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hAABBBE55 || resp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL backpressure got rv=%b rdata=%h err=%b rr=%b want 1 aabbbe55 0 0", resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0]);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    tests++;
    if (resp_valid[0] !== 1'b0) begin fails++; $display("FAIL resp_release got rv=%b want 0", resp_valid[0]); end
  endtask
  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic err;
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'hFC;
    await_resp(0, lat, rd, err);
    resp_ready[0] = 1'b1;
    tests++;
    if (req_ready[0] !== 1'b0) begin fails++; $display("FAIL b2b_ready_in_resp got %b want 0", req_ready[0]); end
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    tests++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      fails++; $display("FAIL b2b_idle got rv=%b rr=%b want 0 1", resp_valid[0], req_ready[0]);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    await_resp(0, lat, rd, err);
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    tests++;
    if (lat !== 3 || rd !== 32'h0BADCAFE) begin fails++; $display("FAIL b2b_second got lat=%0d rdata=%h want 3 0badcafe", lat, rd); end
  endtask
  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic err; int seen;
    xact(0, 1'b1, 32'h20, 32'h20202020, 4'hF, lat, rd, err);
    issue(0, 1'b1, 32'h20, 32'h99999999, 4'hF);
    reset = 1'b0;
    #1;
    tests++;
    if ({req_ready[0], resp_valid[0], resp_err[0], resp_rdata[0]} !== 35'd0) begin
      fails++; $display("FAIL reset_wait got rr=%b rv=%b err=%b rdata=%h want all 0", req_ready[0], resp_valid[0], resp_err[0], resp_rdata[0]);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (resp_valid[0] !== 1'b0) seen++; end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL dropped_resp got %0d resp_valid cycles want 0", seen); end
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
    await_resp(0, lat, rd, err);
    tests++;
    if (rd !== 32'h20202020) begin fails++; $display("FAIL dropped_write got rdata=%h want 20202020", rd); end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (resp_rdata[0] !== 32'h0 || resp_valid[0] !== 1'b0) begin
      fails++; $display("FAIL async_clear got rdata=%h rv=%b want 00000000 0", resp_rdata[0], resp_valid[0]);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_latency0;
    int lat; logic [31:0] rd; logic err;
    xact(1, 1'b1, 32'h8, 32'h0000ABCD, 4'hF, lat, rd, err);
    tests++;
    if (lat !== 1 || err !== 1'b0) begin fails++; $display("FAIL lat0_store got lat=%0d err=%b want 1 0", lat, err); end
    xact(1, 1'b0, 32'h8, 32'h0, 4'h0, lat, rd, err);
    tests++;
    if (lat !== 1 || rd !== 32'h0000ABCD) begin fails++; $display("FAIL lat0_load got lat=%0d rdata=%h want 1 0000abcd", lat, rd); end
    xact(1, 1'b1, 32'h40, 32'h1, 4'hF, lat, rd, err);
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL lat0_range got err=%b want 1", err); end
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; resp_ready[d] = 1'b0;
    end
    test_reset;
    test_store_word;
    test_partial;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_latency0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request accept and response (legal range 0..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  the CPU presents a request.
REQ-006 SHALL have port req_ready  output  1  the block accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  byte enables for stores; bit i enables bits 8i+7:8i.
REQ-011 SHALL have port resp_valid  output  1  a response is presented.
REQ-012 SHALL have port resp_ready  input  1  the CPU accepts the response.
REQ-013 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  the access was misaligned or out of range.

Function
REQ-015 Handshake: a request transfers on a rising edge with req_valid=1 and req_ready=1; a response transfers on a rising edge with resp_valid=1 and resp_ready=1.
REQ-016 FSM states: IDLE, WAIT, RESP; at most one request outstanding.
REQ-017 IDLE: req_ready=1, resp_valid=0; on transfer, latch we/addr/wdata/be and go to WAIT if LATENCY>0, else to RESP.
REQ-018 WAIT: a 4-bit down-counter loaded with LATENCY-1 on accept; when it reaches 0, go to RESP on the next edge; total accept-to-resp_valid delay equals LATENCY+1 cycles.
REQ-019 RESP: resp_valid=1; rdata/err are held stable until the transfer; on transfer, go to IDLE; req_ready=0 in WAIT and RESP.
REQ-020 Error: resp_err=1 when addr[1:0]!=0 or addr[31:2]>=DEPTH; an erroring store SHALL NOT modify memory.
REQ-021 Store: memory is written once, on the edge entering RESP; only enabled bytes change; be=0000 completes without error and changes nothing.
REQ-022 Load: the word at addr[31:2] is read on the edge entering RESP and registered into resp_rdata; be is ignored.
REQ-023 Back-to-back: a response transfer and the next request SHALL NOT share a cycle; IDLE is entered for at least one cycle.
REQ-024 Inputs other than req_valid and resp_ready are don't-care while not part of a transfer.

Reset
REQ-025 With reset low: state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, asynchronously.
REQ-026 req_ready SHALL rise on the first rising edge after reset deasserts.
REQ-027 Memory contents SHALL NOT be cleared by reset; an in-flight request is dropped with no response and no write.

Structure
REQ-028 The shared package holds the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the word-width constant 32.
REQ-029 One sub-module, dmem_array: a DEPTH x 32 byte-writable synchronous RAM with one write port and one read port.

Verification
REQ-030 Store word: addr 0x10, wdata 0xDEADBEEF, be 1111, LATENCY 2 -> resp_valid 3 cycles after accept; err=0, rdata=0.
REQ-031 Partial store: after REQ-030, store 0x00000055 with be 0001, then load 0x10 -> rdata=0xDEADBE55.
REQ-032 Errors: load 0x13 -> err=1, rdata=0; store 4*DEPTH -> err=1; a reload of word 0 is unchanged.
REQ-033 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stable; req_ready=0 throughout.
REQ-034 Reset mid-WAIT: pull reset low during WAIT of a store to 0x20 -> outputs zero immediately; no response appears; a later load of 0x20 returns the prior value.
REQ-035 LATENCY=0: load accepted -> resp_valid on the next cycle.
